word_path_gen: RTL and testbench
================================

Name: word_path_gen

Overview:
- Parametrised next-generation word path for the Am2940-style DMA generator.
- Holds a word register and a word counter of configurable width; counting is up or down with carry chaining.
- Adds selectable terminal-count modes, optional auto-reinitialise from the word register, and sticky and pulsed done flags.
- Sits beside the address path; its done and wco outputs feed the DMA control sequencer and cascaded slices.

Parameters:
- WIDTH, 4, width of word register, word counter and bus_data_in (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- plwr  input  1  load word register from bus_data_in.
- selw  input  1  counter load source: 0 = bus_data_in, 1 = word register.
- plwc  input  1  load word counter.
- enw  input  1  count enable.
- incw  input  1  direction: 1 = increment, 0 = decrement.
- wci  input  1  carry-in from lower slice; counting requires enw=1 and wci=1.
- mode  input  2  terminal mode: 00 zero, 01 compare, 10 carry, 11 none.
- auto_reinit  input  1  on terminal event, reload counter from word register.
- done_clr  input  1  clear sticky done.
- bus_data_in  input  WIDTH  load data.
- word_count_out  output  WIDTH  word counter value.
- word_reg_out  output  WIDTH  word register value.
- wco  output  1  carry-out (combinational).
- done  output  1  sticky terminal flag.
- done_pulse  output  1  one-cycle terminal strobe.

Behaviour:
- Reset (res=0 at edge): word_reg=0, counter=0, done=0, done_pulse=0. wco is forced 0 while res=0. Reset mid-count aborts immediately; no terminal event is generated that cycle.
- Word register: plwr=1 loads bus_data_in next edge; otherwise it holds.
- cnt_en = enw & wci & ~plwc.
- nxt = counter+1 if incw=1, else counter-1, modulo 2^WIDTH.
- Counter priority:
  1. plwc=1: load (selw ? word_reg : bus_data_in).
  2. term=1 and auto_reinit=1: load word_reg.
  3. cnt_en=1: load nxt.
  4. Otherwise hold.
- Simultaneous plwr and plwc with selw=1: the counter takes the pre-update word_reg value. Compare mode also uses the pre-update word_reg.
- wco = enw & wci & (incw ? counter==all-ones : counter==0). This is a single-cycle combinational ripple to the next slice and is asserted regardless of plwc.
- term is evaluated only when cnt_en=1:
  - mode 00: nxt==0.
  - mode 01: nxt==word_reg.
  - mode 10: wrap, i.e. cnt_en & (incw ? counter==all-ones : counter==0).
  - mode 11: never.
- Latency: the terminal step and done/done_pulse appear on the same edge. done_pulse is high exactly one cycle per term; consecutive terms give consecutive pulses.
- done: set on term, cleared on done_clr=1 or plwc=1. Set wins over clear in the same cycle.
- Mode changes take effect on the cycle they are presented; no state is kept per mode.
- auto_reinit=1 with mode 11: no effect.
- Counting while counter equals word_reg in mode 01 without a step does not flag.

Test Plan:
- Reset/load: WIDTH=4, res=0 two cycles, then plwr=1, plwc=1, selw=0, bus=6 -> reg=6, count=6, done=0, wco=0.
- Mode 00 decrement: count=6, enw=1, wci=1, incw=0 -> counts 5,4,3,2,1,0. done and done_pulse go high on the edge giving 0. Next step gives 15 with wco=1 during count=0; done stays 1 with no new pulse.
- Auto-reinit compare: reg=9, count=5, mode 01, incw=1, auto_reinit=1 -> 6,7,8 then 9 (term) reloads 9. done_pulse every fourth cycle does not recur, because the compare next value is 10; also check mode 00 with auto_reinit gives periodic reload to reg value and periodic pulses.
- Carry mode and cascade: count=14, incw=1, mode 10 -> 15 with wco=1, then 0 with term. wci=0 freezes count and suppresses wco.
- Priority/clear: term coincides with done_clr -> done=1. plwc during enw=1 loads and clears done. plwr+plwc with selw=1 loads old reg.
- Reset mid-operation: res=0 while enw=1 at count=1, mode 00 -> count=0, done=0, no done_pulse.

Source files
------------

// File: rtl/word_path_gen.sv
// Word register and word counter slice for the Am2940-style DMA generator.
// Up/down counting with carry chaining, terminal-count modes, auto-reinit and done flags.
module word_path_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             plwr,
    input  logic             selw,
    input  logic             plwc,
    input  logic             enw,
    input  logic             incw,
    input  logic             wci,
    input  logic [1:0]       mode,
    input  logic             auto_reinit,
    input  logic             done_clr,
    input  logic [WIDTH-1:0] bus_data_in,
    output logic [WIDTH-1:0] word_count_out,
    output logic [WIDTH-1:0] word_reg_out,
    output logic             wco,
    output logic             done,
    output logic             done_pulse
);

    localparam logic [1:0] MODE_ZERO    = 2'b00;
    localparam logic [1:0] MODE_COMPARE = 2'b01;
    localparam logic [1:0] MODE_CARRY   = 2'b10;
    localparam logic [1:0] MODE_NONE    = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] counter;
    logic             done_q;
    logic             done_pulse_q;

    logic [WIDTH-1:0] nxt;
    logic             at_end;
    logic             cnt_en;
    logic             term;
    logic [WIDTH-1:0] counter_d;

    // Modulo-2^WIDTH step in the selected direction.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v,
                                                    input logic             up);
        if (up)
            return v + WIDTH'(1);
        else
            return v - WIDTH'(1);
    endfunction

    // The counter sits at the edge of its range for the current direction.
    function automatic logic range_edge(input logic [WIDTH-1:0] v,
                                        input logic             up);
        return up ? (v == ALL_ONES) : (v == ZERO);
    endfunction

    assign nxt    = step_value(counter, incw);
    assign at_end = range_edge(counter, incw);
    assign cnt_en = enw & wci & ~plwc;

    // Carry ripples to the next slice even while this slice is being loaded.
    assign wco = res & enw & wci & at_end;

    always_comb begin
        term = 1'b0;
        case (mode)
            MODE_ZERO:    term = cnt_en & (nxt == ZERO);
            MODE_COMPARE: term = cnt_en & (nxt == word_reg);
            MODE_CARRY:   term = cnt_en & at_end;
            MODE_NONE:    term = 1'b0;
            default:      term = 1'b0;
        endcase
    end

    // Explicit load beats auto-reinit, which beats a plain count step.
    always_comb begin
        counter_d = counter;
        if (plwc)
            counter_d = selw ? word_reg : bus_data_in;
        else if (term && auto_reinit)
            counter_d = word_reg;
        else if (cnt_en)
            counter_d = nxt;
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            word_reg <= ZERO;
            counter  <= ZERO;
        end else begin
            if (plwr)
                word_reg <= bus_data_in;
            counter <= counter_d;
        end
    end

    // A terminal event sets done even when a clear arrives on the same edge.
    always_ff @(posedge clk) begin
        if (!res) begin
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= term;
            if (term)
                done_q <= 1'b1;
            else if (done_clr || plwc)
                done_q <= 1'b0;
        end
    end

    assign word_count_out = counter;
    assign word_reg_out   = word_reg;
    assign done           = done_q;
    assign done_pulse     = done_pulse_q;

endmodule

// File: tb/tb_word_path_gen.sv
// Randomized and directed bench for word_path_gen against a behavioural model.
// The model tracks register, count and flags as plain integers modulo 2^W.
module tb_word_path_gen;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         res, plwr, selw, plwc, enw, incw, wci, auto_reinit, done_clr;
    logic [1:0]   mode;
    logic [W-1:0] bus_data_in;
    logic [W-1:0] word_count_out, word_reg_out;
    logic         wco, done, done_pulse;

    int n_checks = 0;
    int n_errors = 0;

    int m_reg = 0, m_cnt = 0, m_done = 0, m_pulse = 0;

    word_path_gen #(.WIDTH(W)) dut (
        .clk(clk), .res(res), .plwr(plwr), .selw(selw), .plwc(plwc),
        .enw(enw), .incw(incw), .wci(wci), .mode(mode),
        .auto_reinit(auto_reinit), .done_clr(done_clr),
        .bus_data_in(bus_data_in), .word_count_out(word_count_out),
        .word_reg_out(word_reg_out), .wco(wco), .done(done),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_wco();
        if (!res || !enw || !wci) return 0;
        return incw ? int'(m_cnt == MOD - 1) : int'(m_cnt == 0);
    endfunction

    // Spec rules applied to the model state for one rising edge.
    function automatic void model_edge();
        int  nxt, new_cnt;
        bit  cnt_en, term;
        if (!res) begin
            m_reg = 0; m_cnt = 0; m_done = 0; m_pulse = 0;
            return;
        end
        cnt_en = enw && wci && !plwc;
        nxt    = incw ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        case (mode)
            2'b00:   term = cnt_en && nxt == 0;
            2'b01:   term = cnt_en && nxt == m_reg;
            2'b10:   term = cnt_en && (incw ? m_cnt == MOD - 1 : m_cnt == 0);
            default: term = 0;
        endcase
        if (plwc)                    new_cnt = selw ? m_reg : int'(bus_data_in);
        else if (term && auto_reinit) new_cnt = m_reg;
        else if (cnt_en)             new_cnt = nxt;
        else                         new_cnt = m_cnt;
        if (plwr) m_reg = int'(bus_data_in);
        m_cnt = new_cnt;
        if (term)                      m_done = 1;
        else if (done_clr || plwc)     m_done = 0;
        m_pulse = term ? 1 : 0;
    endfunction

    // One clock: check carry-out before the edge, state after it.
    task automatic cycle();
        #2;
        chk("wco", 32'(wco), 32'(model_wco()));
        @(posedge clk);
        model_edge();
        #1;
        chk("count", 32'(word_count_out), 32'(m_cnt));
        chk("reg", 32'(word_reg_out), 32'(m_reg));
        chk("done", 32'(done), 32'(m_done));
        chk("done_pulse", 32'(done_pulse), 32'(m_pulse));
    endtask

    task automatic idle();
        res = 1; plwr = 0; selw = 0; plwc = 0; enw = 0; incw = 0; wci = 0;
        mode = 2'b00; auto_reinit = 0; done_clr = 0; bus_data_in = '0;
    endtask

    task automatic load_cnt(input int v);
        idle(); plwc = 1; bus_data_in = W'(v); cycle(); idle();
    endtask

    task automatic load_reg(input int v);
        idle(); plwr = 1; bus_data_in = W'(v); cycle(); idle();
    endtask

    initial begin
        idle();
        // Reset with counting requested: wco must stay low.
        res = 0; enw = 1; wci = 1; incw = 0;
        cycle(); cycle();
        chk("rst_count", 32'(word_count_out), 0);
        chk("rst_done", 32'(done), 0);

        // Reset/load
        idle(); plwr = 1; plwc = 1; bus_data_in = 4'd6; cycle();
        chk("load_count6", 32'(word_count_out), 6);
        chk("load_reg6", 32'(word_reg_out), 6);

        // Mode 00 decrement to zero and beyond
        idle(); enw = 1; wci = 1; incw = 0; mode = 2'b00;
        repeat (6) cycle();
        chk("dec_zero", 32'(word_count_out), 0);
        chk("dec_pulse", 32'(done_pulse), 1);
        #2 chk("dec_wco_at0", 32'(wco), 1);
        cycle();
        chk("dec_wrap", 32'(word_count_out), 15);
        chk("dec_nopulse", 32'(done_pulse), 0);
        chk("dec_sticky", 32'(done), 1);

        // Auto-reinit compare
        load_reg(9); load_cnt(5);
        idle(); enw = 1; wci = 1; incw = 1; mode = 2'b01; auto_reinit = 1;
        repeat (3) cycle();
        chk("cmp_at8", 32'(word_count_out), 8);
        cycle();
        chk("cmp_reload9", 32'(word_count_out), 9);
        chk("cmp_pulse", 32'(done_pulse), 1);
        repeat (20) cycle();
        mode = 2'b00;
        repeat (25) cycle();

        // Carry mode and cascade
        load_cnt(14);
        idle(); enw = 1; wci = 1; incw = 1; mode = 2'b10;
        cycle();
        chk("carry_15", 32'(word_count_out), 15);
        cycle();
        chk("carry_term", 32'(done_pulse), 1);
        load_cnt(15);
        idle(); enw = 1; wci = 0; incw = 1; mode = 2'b10;
        repeat (2) cycle();
        chk("freeze", 32'(word_count_out), 15);

        // Term coincides with done_clr
        load_cnt(1);
        idle(); enw = 1; wci = 1; mode = 2'b00; done_clr = 1;
        cycle();
        chk("set_wins", 32'(done), 1);
        // Load while enabled clears done
        idle(); enw = 1; wci = 1; plwc = 1; bus_data_in = 4'd7; cycle();
        chk("plwc_clears", 32'(done), 0);
        // plwr+plwc with selw=1 takes the old register
        load_reg(11);
        idle(); plwr = 1; plwc = 1; selw = 1; bus_data_in = 4'd3; cycle();
        chk("old_reg", 32'(word_count_out), 11);
        chk("new_reg", 32'(word_reg_out), 3);

        // Reset mid-operation at the would-be terminal step
        load_cnt(1);
        idle(); enw = 1; wci = 1; mode = 2'b00; res = 0;
        cycle();
        chk("midrst_pulse", 32'(done_pulse), 0);
        chk("midrst_done", 32'(done), 0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            res         = ($urandom_range(0, 63) != 0);
            plwr        = ($urandom_range(0, 7) == 0);
            plwc        = ($urandom_range(0, 7) == 0);
            selw        = 1'($urandom_range(0, 1));
            enw         = ($urandom_range(0, 3) != 0);
            wci         = ($urandom_range(0, 3) != 0);
            incw        = 1'($urandom_range(0, 1));
            mode        = 2'($urandom_range(0, 3));
            auto_reinit = 1'($urandom_range(0, 1));
            done_clr    = ($urandom_range(0, 7) == 0);
            bus_data_in = W'($urandom_range(0, MOD - 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
